// File: rtl/mode_record_if.sv
// mode_record_if
//  Bundles the song-recorder control inputs and the song-table outputs.
//  master: the side that drives record_en/switches/octave_in and reads the table.
//  slave : the recorder itself.
//  Signals:
//   record_en      level; rising edge starts a take, falling edge ends it
//   switches[6:0]  note keys; bit i = note i+1
//   octave_in[1:0] 00 mid, 01 low, 10 high
//   song_packed    note i at [4i+3:4i]   (0 rest, 1..7, F end)
//   octave_packed  octave i at [2i+1:2i]
//   time_continue  duration i at [4i+3:4i], in units
//   length[5:0]    committed entries, terminator excluded
//   recording      high while a take is armed or capturing
//   full           table filled; sticky until next take or reset
//   led_out[6:0]   one-hot of the note being captured, 0 for rest
interface mode_record_if #(
    parameter int SONG_TIME = 56
);
    logic                     record_en;
    logic [6:0]               switches;
    logic [1:0]               octave_in;
    logic [SONG_TIME*4-1:0]   song_packed;
    logic [SONG_TIME*2-1:0]   octave_packed;
    logic [SONG_TIME*4-1:0]   time_continue;
    logic [5:0]               length;
    logic                     recording;
    logic                     full;
    logic [6:0]               led_out;

    modport master (
        output record_en, switches, octave_in,
        input  song_packed, octave_packed, time_continue, length, recording, full, led_out
    );

    modport slave (
        input  record_en, switches, octave_in,
        output song_packed, octave_packed, time_continue, length, recording, full, led_out
    );
endinterface

// File: rtl/mode_record.sv
// mode_record
//  Writer side of the song memory: records notes played on the 7 switches,
//  with octave and duration, into a song table readable by the learn/play
//  reader (4b note, 2b octave, 4b duration in units per entry).
//  Ports:
//   clk    system clock
//   reset  asynchronous, active-low
//   bus    mode_record_if.slave (record_en, switches, octave_in in;
//          song_packed, octave_packed, time_continue, length, recording,
//          full, led_out out)
//  Parameters: TICKS_PER_UNIT clk cycles per duration unit, SONG_TIME table
//  entries (terminator included, at most 64), MAX_UNITS duration saturation.
//  Build option: define RECORD_TRIM_REST_EN to drop a trailing rest entry
//  when a take is stopped; otherwise the trailing rest is committed.
module mode_record #(
    parameter int TICKS_PER_UNIT = 10000000,
    parameter int SONG_TIME      = 56,
    parameter int MAX_UNITS      = 15
) (
    input  logic         clk,
    input  logic         reset,
    mode_record_if.slave bus
);
    localparam int TW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int IW = (SONG_TIME > 1) ? $clog2(SONG_TIME) : 1;
    localparam logic [3:0] NOTE_END = 4'hF;

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, CLOSE, DONE} state_t;

    state_t        state;
    logic          rec_q;
    logic          rec_prev;
    logic [5:0]    key_q;
    logic [5:0]    cur_key;
    logic [TW-1:0] tick;
    logic [3:0]    units;
    logic [5:0]    length_r;
    logic          full_r;
    logic          recording_r;
    logic [6:0]    led_r;
    logic [3:0]    note_mem [SONG_TIME];
    logic [1:0]    oct_mem  [SONG_TIME];
    logic [3:0]    dur_mem  [SONG_TIME];

    logic [3:0]    note_now;
    logic          rise;
    logic          fall;
    logic          key_changed;
    logic          tick_wrap;
    logic          units_sat;
    logic          at_last;
    logic          drop_tail;
    logic [3:0]    held_dur;
    logic [IW-1:0] wr_idx;

    logic [SONG_TIME*4-1:0] song_v;
    logic [SONG_TIME*2-1:0] oct_v;
    logic [SONG_TIME*4-1:0] dur_v;

    // Lowest set switch wins: scanning downward lets lower bits overwrite.
    always_comb begin
        note_now = 4'd0;
        for (int i = 6; i >= 0; i--) begin
            if (bus.switches[i]) note_now = 4'(i + 1);
        end
    end

    // The FSM acts on the registered record_en and key, so edges and key
    // changes are both judged one cycle after the inputs move.
    assign rise        = rec_q & ~rec_prev;
    assign fall        = ~rec_q & rec_prev;
    assign key_changed = (key_q != cur_key);
    assign tick_wrap   = (tick == TW'(TICKS_PER_UNIT - 1));
    assign units_sat   = tick_wrap && (units == 4'(MAX_UNITS - 1));
    assign held_dur    = (units == 4'd0) ? 4'd1 : units;
    assign at_last     = (length_r == 6'(SONG_TIME - 2));
    assign wr_idx      = length_r[IW-1:0];

`ifdef RECORD_TRIM_REST_EN
    assign drop_tail = (cur_key[5:2] == 4'd0);
`else
    assign drop_tail = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rec_q       <= 1'b0;
            rec_prev    <= 1'b0;
            key_q       <= 6'd0;
            cur_key     <= 6'd0;
            tick        <= '0;
            units       <= 4'd0;
            length_r    <= 6'd0;
            full_r      <= 1'b0;
            recording_r <= 1'b0;
            for (int i = 0; i < SONG_TIME; i++) begin
                note_mem[i] <= NOTE_END;
                oct_mem[i]  <= 2'b00;
                dur_mem[i]  <= 4'd0;
            end
        end else begin
            rec_q    <= bus.record_en;
            rec_prev <= rec_q;
            key_q    <= {note_now, bus.octave_in};
            case (state)
                IDLE, DONE: begin
                    if (rise) begin
                        for (int i = 0; i < SONG_TIME; i++) begin
                            note_mem[i] <= NOTE_END;
                            oct_mem[i]  <= 2'b00;
                            dur_mem[i]  <= 4'd0;
                        end
                        length_r    <= 6'd0;
                        full_r      <= 1'b0;
                        recording_r <= 1'b1;
                        state       <= ARMED;
                    end
                end
                ARMED: begin
                    if (fall) begin
                        recording_r <= 1'b0;
                        state       <= CLOSE;
                    end else if (key_q[5:2] != 4'd0) begin
                        cur_key <= key_q;
                        tick    <= '0;
                        units   <= 4'd0;
                        state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (fall) begin
                        if (!drop_tail) begin
                            note_mem[wr_idx] <= cur_key[5:2];
                            oct_mem[wr_idx]  <= cur_key[1:0];
                            dur_mem[wr_idx]  <= held_dur;
                            length_r         <= length_r + 6'd1;
                            if (at_last) full_r <= 1'b1;
                        end
                        recording_r <= 1'b0;
                        state       <= CLOSE;
                    end else if (key_changed || units_sat) begin
                        // A key change closes the note at its real length;
                        // saturation splits it and keeps the same key.
                        note_mem[wr_idx] <= cur_key[5:2];
                        oct_mem[wr_idx]  <= cur_key[1:0];
                        dur_mem[wr_idx]  <= key_changed ? held_dur : 4'(MAX_UNITS);
                        length_r         <= length_r + 6'd1;
                        tick             <= '0;
                        units            <= 4'd0;
                        cur_key          <= key_q;
                        if (at_last) begin
                            full_r      <= 1'b1;
                            recording_r <= 1'b0;
                            state       <= CLOSE;
                        end
                    end else begin
                        tick <= tick_wrap ? '0 : tick + TW'(1);
                        if (tick_wrap) units <= units + 4'd1;
                    end
                end
                CLOSE: begin
                    note_mem[wr_idx] <= NOTE_END;
                    oct_mem[wr_idx]  <= 2'b00;
                    dur_mem[wr_idx]  <= 4'd0;
                    state            <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_r <= 7'd0;
        end else if (state == CAPTURE && cur_key[5:2] != 4'd0) begin
            led_r <= 7'd1 << (cur_key[5:2] - 4'd1);
        end else begin
            led_r <= 7'd0;
        end
    end

    always_comb begin
        song_v = '0;
        oct_v  = '0;
        dur_v  = '0;
        for (int i = 0; i < SONG_TIME; i++) begin
            song_v[4*i +: 4] = note_mem[i];
            oct_v[2*i +: 2]  = oct_mem[i];
            dur_v[4*i +: 4]  = dur_mem[i];
        end
    end

    assign bus.song_packed   = song_v;
    assign bus.octave_packed = oct_v;
    assign bus.time_continue = dur_v;
    assign bus.length        = length_r;
    assign bus.recording     = recording_r;
    assign bus.full          = full_r;
    assign bus.led_out       = led_r;
endmodule

// File: tb/tb_mode_record.sv
// tb_mode_record
//  Drives directed and random takes into mode_record and compares the whole
//  song table, length, full, recording and led_out against a reference built
//  from the recorded per-cycle input history of each take.
module tb_mode_record;
    localparam int T  = 4;
    localparam int ST = 56;
    localparam int MU = 15;
`ifdef RECORD_TRIM_REST_EN
    localparam bit TRIM = 1'b1;
`else
    localparam bit TRIM = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mode_record_if #(.SONG_TIME(ST)) bus ();

    mode_record #(
        .TICKS_PER_UNIT(T),
        .SONG_TIME(ST),
        .MAX_UNITS(MU)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic       rec;
        logic [6:0] sw;
        logic [1:0] oct;
    } sample_t;

    sample_t    smp[$];
    logic [3:0] exp_note [ST];
    logic [1:0] exp_oct  [ST];
    logic [3:0] exp_dur  [ST];
    int         exp_len;
    bit         exp_full;
    int         num_cmp = 0;
    int         num_err = 0;

    function automatic logic [3:0] lowestNote(logic [6:0] sw);
        for (int i = 0; i < 7; i++) begin
            if (sw[i]) return 4'(i + 1);
        end
        return 4'd0;
    endfunction

    function automatic logic [5:0] keyOf(sample_t s);
        return {lowestNote(s.sw), s.oct};
    endfunction

    task automatic addEntry(logic [5:0] k, int dur);
        exp_note[exp_len] = k[5:2];
        exp_oct[exp_len]  = k[1:0];
        exp_dur[exp_len]  = 4'(dur);
        exp_len++;
        if (exp_len == ST - 1) exp_full = 1'b1;
    endtask

    // Reference: find the take in the sample history, split it into runs of
    // equal key and turn each run's length into unit durations.
    task automatic buildExpected();
        int r, m, p, s, e, counted, dur;
        logic [5:0] k;
        for (int i = 0; i < ST; i++) begin
            exp_note[i] = 4'hF;
            exp_oct[i]  = 2'b00;
            exp_dur[i]  = 4'd0;
        end
        exp_len  = 0;
        exp_full = 1'b0;
        r = -1;
        for (int i = 1; i < smp.size(); i++) begin
            if (smp[i].rec && !smp[i-1].rec) begin
                r = i;
                break;
            end
        end
        if (r < 0) return;
        m = smp.size();
        for (int i = r + 1; i < smp.size(); i++) begin
            if (!smp[i].rec) begin
                m = i;
                break;
            end
        end
        p = -1;
        for (int i = r + 1; i < m; i++) begin
            if (lowestNote(smp[i].sw) != 4'd0) begin
                p = i;
                break;
            end
        end
        if (p < 0) return;
        s = p;
        while (s < m && !exp_full) begin
            k = keyOf(smp[s]);
            e = s + 1;
            while (e < m && keyOf(smp[e]) == k) e++;
            counted = e - s - 1;
            while (counted >= MU * T && !exp_full) begin
                addEntry(k, MU);
                counted -= MU * T;
            end
            if (!exp_full && !(TRIM && e == m && k[5:2] == 4'd0)) begin
                dur = counted / T;
                if (dur == 0) dur = 1;
                addEntry(k, dur);
            end
            s = e;
        end
    endtask

    task automatic applyStimulus(logic rec, logic [6:0] sw, logic [1:0] oct, int cycles);
        sample_t s;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bus.record_en = rec;
            bus.switches  = sw;
            bus.octave_in = oct;
            s.rec = rec;
            s.sw  = sw;
            s.oct = oct;
            smp.push_back(s);
        end
    endtask

    task automatic checkOutput(string tag, logic [255:0] observed, logic [255:0] expected);
        num_cmp++;
        assert (observed === expected) else begin
            num_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkTable(string tag, logic exp_rec);
        logic [255:0] es, eo, ed;
        buildExpected();
        es = '0;
        eo = '0;
        ed = '0;
        for (int i = 0; i < ST; i++) begin
            es[4*i +: 4] = exp_note[i];
            eo[2*i +: 2] = exp_oct[i];
            ed[4*i +: 4] = exp_dur[i];
        end
        checkOutput({tag, ".song"},   256'(bus.song_packed),   es);
        checkOutput({tag, ".octave"}, 256'(bus.octave_packed), eo);
        checkOutput({tag, ".dur"},    256'(bus.time_continue), ed);
        checkOutput({tag, ".length"}, 256'(bus.length),        256'(exp_len));
        checkOutput({tag, ".full"},   256'(bus.full),          256'(exp_full));
        checkOutput({tag, ".rec"},    256'(bus.recording),     256'(exp_rec));
        checkOutput({tag, ".led"},    256'(bus.led_out),       256'(0));
    endtask

    task automatic startTake();
        smp.delete();
        applyStimulus(1'b0, 7'd0, 2'b00, 3);
    endtask

    task automatic endTake(string tag);
        applyStimulus(1'b0, 7'd0, 2'b00, 4);
        checkTable(tag, 1'b0);
    endtask

    initial begin
        int         nseg;
        logic [6:0] rsw;
        logic [6:0] exp_led;

        reset         = 1'b0;
        bus.record_en = 1'b0;
        bus.switches  = 7'd0;
        bus.octave_in = 2'b00;
        #23;
        checkTable("reset", 1'b0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] two notes");
        startTake();
        applyStimulus(1'b1, 7'b0000100, 2'b00, 8);
        exp_led = 7'd1 << (lowestNote(7'b0000100) - 4'd1);
        checkOutput("mid.rec", 256'(bus.recording), 256'(1));
        checkOutput("mid.led", 256'(bus.led_out), 256'(exp_led));
        applyStimulus(1'b1, 7'b0000100, 2'b00, 4);
        applyStimulus(1'b1, 7'b0000001, 2'b00, 8);
        endTake("two_notes");

        $display("[TB] priority and octave change");
        startTake();
        applyStimulus(1'b1, 7'b0000101, 2'b00, 4);
        applyStimulus(1'b1, 7'b0000101, 2'b10, 4);
        endTake("prio_oct");

        $display("[TB] long note split");
        startTake();
        applyStimulus(1'b1, 7'b0010000, 2'b01, 140);
        endTake("split");

        $display("[TB] trailing rest");
        startTake();
        applyStimulus(1'b1, 7'b0000010, 2'b00, 8);
        applyStimulus(1'b1, 7'b0000000, 2'b00, 8);
        endTake("tail_rest");

        $display("[TB] empty take");
        startTake();
        applyStimulus(1'b1, 7'b0000000, 2'b01, 6);
        endTake("empty");

        $display("[TB] table full");
        startTake();
        for (int i = 0; i < 56; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 7'b0000001 : 7'b0000010, 2'b00, 2);
        end
        applyStimulus(1'b1, 7'b0001000, 2'b00, 6);
        checkTable("full_held", 1'b0);
        endTake("full_done");

        $display("[TB] random takes");
        for (int t = 0; t < 8; t++) begin
            startTake();
            nseg = $urandom_range(3, 12);
            for (int g = 0; g < nseg; g++) begin
                rsw = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
                applyStimulus(1'b1, rsw, 2'($urandom_range(0, 2)), $urandom_range(1, 14));
            end
            endTake("random");
        end

        $display("[TB] reset mid-take");
        startTake();
        applyStimulus(1'b1, 7'b1000000, 2'b10, 10);
        @(negedge clk);
        reset         = 1'b0;
        bus.record_en = 1'b0;
        bus.switches  = 7'd0;
        smp.delete();
        #2;
        checkTable("reset_mid", 1'b0);
        @(negedge clk);
        reset = 1'b1;

        startTake();
        applyStimulus(1'b1, 7'b0100000, 2'b01, 9);
        applyStimulus(1'b1, 7'b0000011, 2'b00, 5);
        endTake("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
        $finish;
    end
endmodule
